lifo_drain_ctrl: RTL and testbench
==================================

Name: lifo_drain_ctrl

Overview:
Downstream stage of the synchronous LIFO stack. It drives the LIFO read-enable, captures the popped words after the LIFO's read latency, and presents them on a valid/ready stream through a 2-entry output buffer. A drain is started by a `start` pulse and runs for a programmed number of words, or until the LIFO is empty.

Parameters:
DWIDTH, 4, data word width; matches the LIFO memory width.
CNTW, 4, width of burst_len and the internal word counter.
RD_LAT, 1, cycles from lifo_rd_en high to valid lifo_data; legal range 1..3.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; begins a drain; ignored while busy.
burst_len  in  CNTW  words to pop, sampled on start; 0 = drain until LIFO empty.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the drain completes.
lifo_empty  in  1  LIFO empty flag (registered in LIFO).
lifo_rd_en  out  1  pop request to LIFO; write enable is never driven by this block.
lifo_data  in  DWIDTH  LIFO read data.
out_data  out  DWIDTH  head of output buffer.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accept; transfer = out_valid & out_ready.
out_count  out  CNTW  words delivered downstream in the current or last drain.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, buffer empty, in-flight flag 0, delay pipe cleared. Assertion mid-drain aborts immediately; words in flight are discarded.
- FSM states:
  - IDLE: on start, latch burst_len, clear pop count and out_count, go to DRAIN; busy=1 next cycle.
  - DRAIN: issues pops (rules below). Go to FLUSH when pop count == latched len (len≠0), or when lifo_empty=1 with no pop in flight.
  - FLUSH: wait until no pop is in flight and the buffer is empty. Then pulse done and go to IDLE; busy=0 in the same cycle done=1.
- Pop issue, registered: lifo_rd_en=1 for exactly one cycle when all of the following hold:
  - state is DRAIN;
  - lifo_empty=0;
  - no pop is in flight;
  - buffer occupancy < 2;
  - the target has not been reached.
- At most one pop is outstanding, so the LIFO's lagging empty flag is always current. Maximum pop rate is one per RD_LAT+1 cycles.
- Capture: a shift pipe of depth RD_LAT tracks the pop. lifo_data is written into the buffer in the cycle the pipe output is 1, and the in-flight flag clears in that cycle.
- Output buffer: 2-entry FIFO, registered, first-in-first-out.
  - out_valid = occupancy != 0.
  - Simultaneous capture and downstream transfer keeps occupancy unchanged.
  - out_data holds stable while out_valid=1 and out_ready=0.
- out_count increments on each transfer and saturates at 2^CNTW-1.
- The pop counter is CNTW wide. burst_len=0 means unlimited; the counter wraps harmlessly and the drain is terminated only by lifo_empty.
- lifo_empty high while a pop is in flight: the in-flight word is still captured.
- A start pulse while busy is ignored; no latch, no error.

Optional Feature:
LIFO_DRAIN_LAST_EN: adds output port out_last (1 bit).
- It is high with the final word of the drain: the buffered word whose transfer leaves the buffer empty, no pop in flight, and the FSM in FLUSH.
- Tagging is done at capture time with a per-entry last bit, set when this is the final pop.
- With burst_len=0, the final pop is detected when lifo_empty=1 after capture.
- Without the macro, the port and tag bits do not exist and behaviour is otherwise identical.

Test Plan:
- LIFO model holds 5,6,7 (7 on top); start with burst_len=2 and out_ready=1 -> two lifo_rd_en pulses ≥RD_LAT+1 apart; out_data 7 then 6; done pulse; out_count=2; 5 remains in the LIFO.
- Same contents; burst_len=0 -> out_data 7,6,5; the pop stops on lifo_empty; done; out_count=3; no pop is issued while empty.
- out_ready=0 for 20 cycles, burst_len=4, 4 words present -> exactly 2 pops, then lifo_rd_en stays 0 and out_data is stable. Release out_ready -> remaining 2 pops issued; order preserved.
- LIFO empty at start -> no lifo_rd_en; done within 3 cycles; out_count=0.
- Assert rst mid-drain with a pop in flight -> all outputs 0 the same cycle; after release, a new start with burst_len=1 delivers the current LIFO top.
- With LIFO_DRAIN_LAST_EN, burst_len=3 -> out_last=1 only on the third transfer; with burst_len=0 and 2 words, out_last=1 on the second.

Source files
------------

// File: rtl/lifo_drain_ctrl.sv
// lifo_drain_ctrl: pops a burst from a synchronous LIFO into a 2-entry valid/ready output buffer
// Optional feature: define LIFO_DRAIN_LAST_EN to add out_last, marking the final word of a drain.
module lifo_drain_ctrl #(
    parameter int DWIDTH = 4,
    parameter int CNTW   = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNTW-1:0]   burst_len,
    output logic              busy,
    output logic              done,
    input  logic              lifo_empty,
    output logic              lifo_rd_en,
    input  logic [DWIDTH-1:0] lifo_data,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef LIFO_DRAIN_LAST_EN
    output logic              out_last,
`endif
    output logic [CNTW-1:0]   out_count
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
    state_t            r_state, w_next;
    logic [CNTW-1:0]   r_len, r_pcnt, r_cnt;
    logic              r_inflight, r_rd_en, r_done;
    logic [RD_LAT-1:0] r_pipe;
    logic [1:0]        r_occ, w_occ_n;
    logic [DWIDTH-1:0] r_b0, r_b1;
    logic              w_start, w_cap, w_xfer, w_reached, w_issue, w_fin, w_wr0;

    assign w_start   = (r_state == IDLE) && start;
    assign w_cap     = r_pipe[RD_LAT-1];
    assign w_xfer    = out_valid && out_ready;
    assign w_reached = (r_len != '0) && (r_pcnt == r_len);
    assign w_occ_n   = r_occ + {1'b0, w_cap} - {1'b0, w_xfer};
    // A pop may issue in the same cycle the previous one lands, so the LIFO's empty flag is already current
    assign w_issue   = (r_state == DRAIN) && !lifo_empty && (!r_inflight || w_cap) && (w_occ_n < 2'd2) && !w_reached;
    assign w_fin     = (r_state == FLUSH) && !r_inflight && (r_occ == 2'd0);
    assign w_wr0     = (r_occ == {1'b0, w_xfer});

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign lifo_rd_en = r_rd_en;
    assign out_data   = r_b0;
    assign out_valid  = (r_occ != 2'd0);
    assign out_count  = r_cnt;

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    // Next-state: drain until target or empty, then flush the buffer and in-flight pop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? DRAIN : IDLE;
            DRAIN:   w_next = (w_reached || (lifo_empty && !r_inflight)) ? FLUSH : DRAIN;
            FLUSH:   w_next = w_fin ? IDLE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    // Pop issue, read-latency pipe, counters and done pulse
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_rd_en    <= 1'b0;
            r_pipe     <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_pcnt     <= '0;
            r_cnt      <= '0;
        end else begin
            r_rd_en    <= w_issue;
            r_pipe     <= RD_LAT'({r_pipe, r_rd_en});
            r_inflight <= w_issue || (r_inflight && !w_cap);
            r_done     <= w_fin;
            if (w_start) begin
                r_len  <= burst_len;
                r_pcnt <= '0;
            end else if (w_issue) r_pcnt <= r_pcnt + 1'b1;
            if (w_start) r_cnt <= '0;
            else if (w_xfer && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end

    // Two-entry output FIFO: head in r_b0, capture goes to the first free slot after any transfer
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_occ <= 2'd0;
            r_b0  <= '0;
            r_b1  <= '0;
        end else begin
            r_occ <= w_occ_n;
            if (w_xfer) r_b0 <= r_b1;
            if (w_cap && w_wr0) r_b0 <= lifo_data;
            if (w_cap && !w_wr0) r_b1 <= lifo_data;
        end

`ifdef LIFO_DRAIN_LAST_EN
    logic r_l0, r_l1, w_last_in;
    // Final pop: burst target reached, or the LIFO ran dry by the time the word lands
    assign w_last_in = w_reached || lifo_empty;
    assign out_last  = out_valid && r_l0;

    // Per-entry last tags, moving in lockstep with the data entries
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_l0 <= 1'b0;
            r_l1 <= 1'b0;
        end else begin
            if (w_xfer) r_l0 <= r_l1;
            if (w_cap && w_wr0) r_l0 <= w_last_in;
            if (w_cap && !w_wr0) r_l1 <= w_last_in;
        end
`endif
endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// tb_lifo_drain_ctrl: directed bench for lifo_drain_ctrl with a behavioural RD_LAT=1 LIFO
module tb_lifo_drain_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic       busy, done, lifo_empty, lifo_rd_en, out_valid;
    logic [3:0] lifo_data = 4'd0, out_data, out_count;
    logic       last_w;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    lifo_drain_ctrl #(.DWIDTH(4), .CNTW(4), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
        .lifo_empty(lifo_empty), .lifo_rd_en(lifo_rd_en), .lifo_data(lifo_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef LIFO_DRAIN_LAST_EN
        .out_last(last_w),
`endif
        .out_count(out_count)
    );
`ifndef LIFO_DRAIN_LAST_EN
    assign last_w = 1'b0;
`endif

    // LIFO model: registered empty, data one cycle after rd_en
    logic [3:0] stk [0:7];
    int         cnt = 0, ld_n = 0;
    logic       ld = 1'b0;
    assign lifo_empty = (cnt == 0);
    always @(posedge clk)
        if (ld) cnt <= ld_n;
        else if (lifo_rd_en && cnt > 0) begin
            lifo_data <= stk[cnt-1];
            cnt <= cnt - 1;
        end

    // Scoreboard of transfers and pop cycles
    int         cyc = 0, xn = 0, rn = 0, epop = 0;
    logic [3:0] xd [0:63];
    logic       xl [0:63];
    int         rt [0:63];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            xd[xn] <= out_data;
            xl[xn] <= last_w;
            xn <= xn + 1;
        end
        if (lifo_rd_en) begin
            rt[rn] <= cyc;
            rn <= rn + 1;
            if (cnt == 0) epop <= epop + 1;
        end
    end

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) stk[i] = 4'(base + i);
        @(negedge clk); ld = 1'b1; ld_n = n;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic start_drain(input logic [3:0] len);
        @(negedge clk); burst_len = len; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout got %b want 1", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", busy); end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, lifo_rd_en, out_valid, out_data, out_count} !== 12'd0)
            begin errors++; $display("FAIL reset_outputs got %h want 000", {busy, done, lifo_rd_en, out_valid, out_data, out_count}); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_burst;
        int xb, rb, n;
        load(3, 5); out_ready = 1'b1; xb = xn; rb = rn;
        start_drain(4'd2);
        wait_done(n);
        checks++;
        if (xn - xb !== 2 || xd[xb] !== 4'd7 || xd[xb+1] !== 4'd6)
            begin errors++; $display("FAIL burst_data got n=%0d %0d,%0d want 2 7,6", xn - xb, xd[xb], xd[xb+1]); end
        checks++;
        if (out_count !== 4'd2) begin errors++; $display("FAIL burst_count got %0d want 2", out_count); end
        checks++;
        if (rn - rb !== 2 || rt[rb+1] - rt[rb] < 2)
            begin errors++; $display("FAIL burst_pops got n=%0d gap=%0d want 2 >=2", rn - rb, rt[rb+1] - rt[rb]); end
        checks++;
        if (cnt !== 1 || stk[0] !== 4'd5) begin errors++; $display("FAIL burst_left got %0d want 1", cnt); end
    endtask

    task automatic test_unlimited;
        int xb, rb, eb, n;
        load(3, 5); out_ready = 1'b1; xb = xn; rb = rn; eb = epop;
        start_drain(4'd0);
        wait_done(n);
        checks++;
        if (xn - xb !== 3 || xd[xb] !== 4'd7 || xd[xb+1] !== 4'd6 || xd[xb+2] !== 4'd5)
            begin errors++; $display("FAIL unl_data got n=%0d %0d,%0d,%0d want 3 7,6,5", xn - xb, xd[xb], xd[xb+1], xd[xb+2]); end
        checks++;
        if (out_count !== 4'd3) begin errors++; $display("FAIL unl_count got %0d want 3", out_count); end
        checks++;
        if (rn - rb !== 3 || epop !== eb) begin errors++; $display("FAIL unl_pops got %0d empty_pops=%0d want 3 0", rn - rb, epop - eb); end
    endtask

    task automatic test_backpressure;
        int xb, rb, n;
        load(4, 1); out_ready = 1'b0; xb = xn; rb = rn;
        start_drain(4'd4);
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd4) begin errors++; $display("FAIL bp_head_early got v=%b d=%0d want 1 4", out_valid, out_data); end
        @(negedge clk); burst_len = 4'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (13) @(negedge clk);
        checks++;
        if (rn - rb !== 2 || lifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_pops got %0d rd=%b want 2 0", rn - rb, lifo_rd_en); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd4) begin errors++; $display("FAIL bp_head_stable got v=%b d=%0d want 1 4", out_valid, out_data); end
        out_ready = 1'b1;
        wait_done(n);
        checks++;
        if (xn - xb !== 4 || xd[xb] !== 4'd4 || xd[xb+1] !== 4'd3 || xd[xb+2] !== 4'd2 || xd[xb+3] !== 4'd1)
            begin errors++; $display("FAIL bp_order got n=%0d %0d,%0d,%0d,%0d want 4 4,3,2,1", xn - xb, xd[xb], xd[xb+1], xd[xb+2], xd[xb+3]); end
        checks++;
        if (out_count !== 4'd4 || rn - rb !== 4) begin errors++; $display("FAIL bp_count got %0d pops=%0d want 4 4", out_count, rn - rb); end
    endtask

    task automatic test_empty;
        int rb, n;
        load(0, 0); out_ready = 1'b1; rb = rn;
        start_drain(4'd3);
        wait_done(n);
        checks++;
        if (n > 3) begin errors++; $display("FAIL empty_latency got %0d want <=3", n); end
        checks++;
        if (rn !== rb || out_count !== 4'd0) begin errors++; $display("FAIL empty_pops got %0d cnt=%0d want 0 0", rn - rb, out_count); end
    endtask

    task automatic test_reset_mid;
        int seen, k, xb, n;
        load(4, 1); out_ready = 1'b1;
        start_drain(4'd4);
        seen = 0; k = 0;
        while (seen < 2 && k < 50) begin @(negedge clk); k++; if (lifo_rd_en) seen++; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_count !== 4'd1) begin errors++; $display("FAIL mid_pre got busy=%b cnt=%0d want 1 1", busy, out_count); end
        rst = 1'b0; #1;
        checks++;
        if ({busy, done, lifo_rd_en, out_valid, out_data, out_count} !== 12'd0)
            begin errors++; $display("FAIL mid_reset got %h want 000", {busy, done, lifo_rd_en, out_valid, out_data, out_count}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); xb = xn;
        start_drain(4'd1);
        wait_done(n);
        checks++;
        if (xn - xb !== 1 || xd[xb] !== 4'd2 || out_count !== 4'd1)
            begin errors++; $display("FAIL mid_restart got n=%0d d=%0d cnt=%0d want 1 2 1", xn - xb, xd[xb], out_count); end
    endtask

`ifdef LIFO_DRAIN_LAST_EN
    task automatic test_last;
        int xb, n;
        load(4, 1); out_ready = 1'b1; xb = xn;
        start_drain(4'd3);
        wait_done(n);
        checks++;
        if (xn - xb !== 3 || {xl[xb], xl[xb+1], xl[xb+2]} !== 3'b001)
            begin errors++; $display("FAIL last_burst got n=%0d %b%b%b want 3 001", xn - xb, xl[xb], xl[xb+1], xl[xb+2]); end
        load(2, 8); xb = xn;
        start_drain(4'd0);
        wait_done(n);
        checks++;
        if (xn - xb !== 2 || {xl[xb], xl[xb+1]} !== 2'b01 || xd[xb] !== 4'd9)
            begin errors++; $display("FAIL last_unl got n=%0d %b%b d=%0d want 2 01 9", xn - xb, xl[xb], xl[xb+1], xd[xb]); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_burst;
        test_unlimited;
        test_backpressure;
        test_empty;
        test_reset_mid;
`ifdef LIFO_DRAIN_LAST_EN
        test_last;
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
